// File: rtl/obstacle_scheduler.sv
// ============================================================================
//  Module   : obstacle_scheduler
//  Purpose  : Scans the obstacle descriptor ROM once per frame, culls against
//             the camera window and streams the vertices of visible obstacles.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module obstacle_scheduler #(
    parameter int WORLD_BITS              = 32,
    parameter int MAX_NUM_VERTICES        = 8,
    parameter int NUM_OBSTACLES           = 64,
    parameter int MAX_OBSTACLES_ON_SCREEN = 16,
    parameter int SCREEN_W                = 1280,
    parameter int SCREEN_H                = 720,
    parameter int VERT_ADDR_BITS          = 9
) (
    input  logic                                      clk_in,
    input  logic                                      rst_n_in,
    input  logic                                      start_in,
    input  logic signed [WORLD_BITS-1:0]              camera_x_in,
    input  logic signed [WORLD_BITS-1:0]              camera_y_in,
    output logic [$clog2(NUM_OBSTACLES)-1:0]          desc_addr_out,
    input  logic signed [WORLD_BITS-1:0]              desc_min_x_in,
    input  logic signed [WORLD_BITS-1:0]              desc_min_y_in,
    input  logic signed [WORLD_BITS-1:0]              desc_max_x_in,
    input  logic signed [WORLD_BITS-1:0]              desc_max_y_in,
    input  logic [VERT_ADDR_BITS-1:0]                 desc_base_in,
    input  logic [$clog2(MAX_NUM_VERTICES+1)-1:0]     desc_num_sides_in,
    output logic [VERT_ADDR_BITS-1:0]                 vert_addr_out,
    input  logic signed [WORLD_BITS-1:0]              vert_x_in,
    input  logic signed [WORLD_BITS-1:0]              vert_y_in,
    output logic                                      valid_out,
    output logic signed [WORLD_BITS-1:0]              x_out,
    output logic signed [WORLD_BITS-1:0]              y_out,
    output logic                                      done_out,
    output logic                                      busy_out,
    output logic                                      overflow_out
);

    localparam int c_idx_bits = $clog2(NUM_OBSTACLES);
    localparam int c_ns_bits  = $clog2(MAX_NUM_VERTICES+1);
    localparam int c_cnt_bits = $clog2(MAX_OBSTACLES_ON_SCREEN+1);

    localparam logic [c_idx_bits-1:0]     c_last_idx  = c_idx_bits'(NUM_OBSTACLES-1);
    localparam logic [c_ns_bits-1:0]      c_max_sides = c_ns_bits'(MAX_NUM_VERTICES);
    localparam logic [c_cnt_bits-1:0]     c_max_on    = c_cnt_bits'(MAX_OBSTACLES_ON_SCREEN);
    localparam logic signed [WORLD_BITS:0] c_w_m1     = (WORLD_BITS+1)'(SCREEN_W-1);
    localparam logic signed [WORLD_BITS:0] c_h_m1     = (WORLD_BITS+1)'(SCREEN_H-1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DESC_FETCH  = 3'd1,
        DESC_CHECK  = 3'd2,
        VERT_STREAM = 3'd3,
        GAP         = 3'd4,
        DONE        = 3'd5
    } state_t;

    state_t                          r_state, w_next;
    logic [c_idx_bits-1:0]           r_idx;
    logic [c_cnt_bits-1:0]           r_count;
    logic [c_ns_bits-1:0]            r_left;
    logic [VERT_ADDR_BITS-1:0]       r_vert_addr;
    logic signed [WORLD_BITS-1:0]    r_cam_x, r_cam_y, r_x, r_y;
    logic                            r_wait, r_v1, r_v2, r_valid, r_overflow;

    logic                            w_accept, w_skip, w_enter_stream, w_gap_done, w_ovf_set;
    logic                            w_visible, w_sides_ok;
    logic signed [WORLD_BITS:0]      w_right, w_bottom, w_min_x, w_min_y;

    // Right/bottom edges need one extra bit so cam + SCREEN - 1 cannot wrap.
    assign w_right  = $signed({r_cam_x[WORLD_BITS-1], r_cam_x}) + c_w_m1;
    assign w_bottom = $signed({r_cam_y[WORLD_BITS-1], r_cam_y}) + c_h_m1;
    assign w_min_x  = $signed({desc_min_x_in[WORLD_BITS-1], desc_min_x_in});
    assign w_min_y  = $signed({desc_min_y_in[WORLD_BITS-1], desc_min_y_in});

    assign w_sides_ok = (desc_num_sides_in != '0) && (desc_num_sides_in <= c_max_sides);
    assign w_visible  = w_sides_ok
                     && (desc_max_x_in >= r_cam_x) && (w_min_x <= w_right)
                     && (desc_max_y_in >= r_cam_y) && (w_min_y <= w_bottom);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        w_skip         = 1'b0;
        w_enter_stream = 1'b0;
        w_gap_done     = 1'b0;
        w_ovf_set      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_accept = 1'b1;
                    w_next   = DESC_FETCH;
                end
            end
            DESC_FETCH: begin
                if (r_wait) w_next = DESC_CHECK;
            end
            DESC_CHECK: begin
                if (w_visible && (r_count < c_max_on)) begin
                    w_enter_stream = 1'b1;
                    w_next         = VERT_STREAM;
                end else begin
                    w_ovf_set = w_visible;
                    w_skip    = 1'b1;
                    w_next    = (r_idx == c_last_idx) ? DONE : DESC_FETCH;
                end
            end
            VERT_STREAM: begin
                if (r_left == c_ns_bits'(1)) w_next = GAP;
            end
            GAP: begin
                // Wait for the ROM pipeline to drain and one low output cycle.
                if (!r_v1 && !r_v2 && !r_valid) begin
                    w_gap_done = 1'b1;
                    w_next     = (r_idx == c_last_idx) ? DONE : DESC_FETCH;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_idx       <= '0;
            r_count     <= '0;
            r_left      <= '0;
            r_vert_addr <= '0;
            r_cam_x     <= '0;
            r_cam_y     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_wait      <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_wait <= (r_state == DESC_FETCH) && !r_wait;
            if (w_accept) begin
                r_cam_x    <= camera_x_in;
                r_cam_y    <= camera_y_in;
                r_overflow <= 1'b0;
                r_idx      <= '0;
                r_count    <= '0;
            end
            if (w_ovf_set) r_overflow <= 1'b1;
            if (w_skip)    r_idx      <= r_idx + c_idx_bits'(1);
            if (w_gap_done) begin
                r_idx   <= r_idx + c_idx_bits'(1);
                r_count <= r_count + c_cnt_bits'(1);
            end
            if (w_enter_stream) begin
                r_vert_addr <= desc_base_in;
                r_left      <= desc_num_sides_in;
            end else if (r_state == VERT_STREAM) begin
                r_vert_addr <= r_vert_addr + VERT_ADDR_BITS'(1);
                r_left      <= r_left - c_ns_bits'(1);
            end
            // Two ROM latency stages, then the output register.
            r_v1    <= (r_state == VERT_STREAM);
            r_v2    <= r_v1;
            r_valid <= r_v2;
            if (r_v2) begin
                r_x <= vert_x_in;
                r_y <= vert_y_in;
            end
        end
    end

    assign desc_addr_out = r_idx;
    assign vert_addr_out = r_vert_addr;
    assign valid_out     = r_valid;
    assign x_out         = r_x;
    assign y_out         = r_y;
    assign done_out      = (r_state == DONE);
    assign busy_out      = (r_state != IDLE);
    assign overflow_out  = r_overflow;

endmodule

`default_nettype wire

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter WORLD_BITS, default 32: signed world-coordinate width.
REQ-002 Parameter MAX_NUM_VERTICES, default 8: largest legal vertex count per obstacle.
REQ-003 Parameter NUM_OBSTACLES, default 64: number of entries in the obstacle descriptor ROM.
REQ-004 Parameter MAX_OBSTACLES_ON_SCREEN, default 16: most obstacles emitted per frame.
REQ-005 Parameters SCREEN_W = 1280 and SCREEN_H = 720: visible window size in world units.
REQ-006 Parameter VERT_ADDR_BITS, default 9: vertex ROM address width.
REQ-007 Port clk_in, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-008 Port rst_n_in, input, 1 bit: reset, asynchronous assert, active-low.
REQ-009 Port start_in, input, 1 bit: frame-start pulse.
REQ-010 Ports camera_x_in and camera_y_in, input, WORLD_BITS signed each: window top-left, latched on an accepted start.
REQ-011 Port desc_addr_out, output, clog2(NUM_OBSTACLES) bits: descriptor ROM address.
REQ-012 Ports desc_min_x_in, desc_min_y_in, desc_max_x_in and desc_max_y_in, input, WORLD_BITS signed each: obstacle bounding box, inclusive.
REQ-013 Port desc_base_in, input, VERT_ADDR_BITS: address of the obstacle's first vertex.
REQ-014 Port desc_num_sides_in, input, clog2(MAX_NUM_VERTICES+1) bits: vertex count.
REQ-015 Port vert_addr_out, output, VERT_ADDR_BITS: vertex ROM address.
REQ-016 Ports vert_x_in and vert_y_in, input, WORLD_BITS signed each: vertex data.
REQ-017 Port valid_out, output, 1 bit: x_out/y_out carry a vertex of the current obstacle.
REQ-018 Ports x_out and y_out, output, WORLD_BITS signed each: vertex coordinates.
REQ-019 Port done_out, output, 1 bit: one-cycle end-of-frame pulse.
REQ-020 Port busy_out, output, 1 bit: high from an accepted start until done_out inclusive.
REQ-021 Port overflow_out, output, 1 bit: sticky; a visible obstacle was dropped this frame.

Function
REQ-022 Both ROMs SHALL be treated as synchronous with fixed 2-cycle latency: an address driven in cycle t returns data in cycle t+2.
REQ-023 The FSM states SHALL be IDLE, DESC_FETCH, DESC_CHECK, VERT_STREAM, GAP and DONE.
REQ-024 In IDLE, a start_in high SHALL do three things: latch the camera, clear overflow_out, and go to DESC_FETCH with obstacle index 0.
REQ-025 A start_in received outside IDLE SHALL be ignored.
REQ-026 DESC_FETCH SHALL drive desc_addr_out = index, wait 2 cycles, then enter DESC_CHECK.
REQ-027 An obstacle SHALL be visible iff all of the following hold, using signed compares with right/bottom edges computed at WORLD_BITS+1 bits so that no overflow occurs:
  - max_x >= cam_x
  - min_x <= cam_x + SCREEN_W - 1
  - max_y >= cam_y
  - min_y <= cam_y + SCREEN_H - 1
REQ-028 An obstacle with num_sides = 0 or num_sides > MAX_NUM_VERTICES SHALL be skipped as invisible.
REQ-029 In DESC_CHECK, an invisible obstacle SHALL advance to the next index.
REQ-030 In DESC_CHECK, a visible obstacle SHALL enter VERT_STREAM when the emitted count < MAX_OBSTACLES_ON_SCREEN; otherwise it SHALL set overflow_out and skip.
REQ-031 VERT_STREAM SHALL issue vert_addr_out = base, base+1, … base+n-1 on consecutive cycles, wrapping modulo 2^VERT_ADDR_BITS.
REQ-032 VERT_STREAM SHALL register the returned data to x_out/y_out with valid_out high for exactly n contiguous cycles.
REQ-033 After the last valid vertex, GAP SHALL hold valid_out low for at least 1 cycle before any further valid_out, and SHALL then increment the emitted count.
REQ-034 After index NUM_OBSTACLES-1 is processed, the block SHALL enter DONE.
REQ-035 done_out SHALL pulse exactly 2 cycles after the last valid_out high cycle, or 1 cycle after the last DESC_CHECK if nothing was emitted.
REQ-036 done_out and valid_out SHALL never be high in the same cycle.
REQ-037 After done_out the block SHALL return to IDLE, with busy_out low from the next cycle.
REQ-038 x_out/y_out SHALL hold their last value while valid_out is low.

Reset
REQ-039 rst_n_in low SHALL force IDLE at once, including mid-frame and mid-stream.
REQ-040 During reset, valid_out, done_out, busy_out and overflow_out SHALL be 0; x_out, y_out, desc_addr_out and vert_addr_out SHALL be 0; the index and emitted count SHALL be 0.
REQ-041 After reset deasserts, the first start_in SHALL be accepted normally.

Verification
REQ-042 Camera (0,0); obstacle 0 has bbox (100,100)-(200,200) and 4 vertices; all others are off-screen. Required: valid_out high for 4 contiguous cycles with the ROM vertices in order, then done_out 2 cycles after the last vertex.
REQ-043 Edge touch: bbox min_x = 1279 at camera (0,0) is visible; min_x = 1280 is skipped. Repeat with cam_x = -5 and max_x = -5 (visible).
REQ-044 20 visible 3-vertex obstacles. Required: exactly 16 valid bursts, each separated by ≥1 low cycle, overflow_out = 1, done_out once.
REQ-045 No visible obstacles. Required: no valid_out, one done_out pulse, overflow_out = 0.
REQ-046 num_sides = 0 and num_sides = 9 entries. Required: both skipped; a start_in pulse mid-frame is ignored.
REQ-047 rst_n_in low during a VERT_STREAM burst. Required: all outputs read 0 within the same cycle; a new start yields a full, correct frame.
